// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control slice: FSM states,
// opcodes and datapath mux/ALU selects.
package mips_ctrl_pkg;

  localparam int OPC_W_DEF = 6;
  localparam int ST_W_DEF  = 4;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    JUMP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Control/datapath boundary of the multicycle MIPS controller.
// master = controller side, slave = datapath side.
interface mips_mc_ctrl_if #(
  parameter int OPC_W = 6,
  parameter int ST_W  = 4
);
  logic [OPC_W-1:0] opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_en;
  logic [1:0]       pc_src;
  logic             iord;
  logic             mem_rd;
  logic             mem_wr;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             illegal;
  logic [ST_W-1:0]  state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, pc_src, iord, mem_rd, mem_wr, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           illegal, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, pc_src, iord, mem_rd, mem_wr, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           illegal, state
  );
endinterface

// File: rtl/mips_mc_ctrl_pc_gate.sv
// PC load qualification: unconditional PC writes OR a taken branch.
module mips_pc_gate (
  input  logic pc_write,
  input  logic branch,
  input  logic zero,
  output logic pc_en
);
  logic branch_taken;

  and u_branch_and (branch_taken, branch, zero);

  assign pc_en = pc_write | branch_taken;
endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main control FSM: one instruction at a time, stalling
// in FETCH/MEMRD/MEMWR until the memory reports ready.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int ST_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mips_mc_ctrl_if.master   bus
);

  state_e     state_q;
  state_e     state_d;

  logic       pc_write;
  logic       branch;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_rd;
  logic       mem_wr;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = IDLE;
    pc_write   = 1'b0;
    branch     = 1'b0;
    pc_src     = PCSRC_ALU;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      // IR and PC+4 commit only in the cycle the memory delivers the word
      FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else begin
          state_d  = FETCH;
        end
      end

      // Branch target is precomputed here while the opcode is decoded
      DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end

      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      end

      MEMRD: begin
        mem_rd  = 1'b1;
        iord    = 1'b1;
        state_d = bus.mem_ready ? MEMWB : MEMRD;
      end

      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end

      MEMWR: begin
        mem_wr  = 1'b1;
        iord    = 1'b1;
        state_d = bus.mem_ready ? FETCH : MEMWR;
      end

      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = ALUWB;
      end

      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end

      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
        state_d   = FETCH;
      end

      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = ADDIWB;
      end

      ADDIWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end

      JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        state_d  = FETCH;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  mips_pc_gate u_pc_gate (
    .pc_write (pc_write),
    .branch   (branch),
    .zero     (bus.zero),
    .pc_en    (pc_en)
  );

  assign bus.pc_en      = pc_en;
  assign bus.pc_src     = pc_src;
  assign bus.iord       = iord;
  assign bus.mem_rd     = mem_rd;
  assign bus.mem_wr     = mem_wr;
  assign bus.ir_write   = ir_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_write  = reg_write;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.illegal    = illegal;
  assign bus.state      = ST_W'(state_q);

  a_mem_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_rd && mem_wr));
  a_wr_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(reg_write && pc_en));
  a_irw_fetch: assert property (@(posedge clk) disable iff (!rst_n)
    ir_write |-> (state_q == FETCH));

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: a micro-step queue model predicts state
// and outputs every cycle; per-instruction literals pin latency and pulses.
module tb_mips_mc_ctrl;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_mc_ctrl_if #(.OPC_W(6), .ST_W(4)) bus ();

  mips_mc_ctrl #(.OPC_W(6), .ST_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } outs_t;

  int errors = 0;
  int checks = 0;

  state_e m_state = IDLE;
  state_e m_q[$];
  int fetch_stall = 0;
  int mem_stall   = 0;

  int cnt_memwr, cnt_regwr, cnt_ill, cnt_br, cnt_irw;

  function automatic logic known_op(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                      6'b001000, 6'b000010};
  endfunction

  // Output table keyed by the step the instruction is in
  function automatic outs_t model_outs(input state_e s, input logic [5:0] op,
                                       input logic z, input logic mr);
    outs_t o;
    o = '0;
    case (s)
      FETCH:  begin o.mem_rd = 1; o.alu_src_b = 2'd1; o.ir_write = mr; o.pc_en = mr; end
      DECODE: begin o.alu_src_b = 2'd3; o.illegal = !known_op(op); end
      MEMADR: begin o.alu_src_a = 1; o.alu_src_b = 2'd2; end
      MEMRD:  begin o.mem_rd = 1; o.iord = 1; end
      MEMWB:  begin o.reg_write = 1; o.mem_to_reg = 1; end
      MEMWR:  begin o.mem_wr = 1; o.iord = 1; end
      EXEC:   begin o.alu_src_a = 1; o.alu_op = 2'd2; end
      ALUWB:  begin o.reg_write = 1; o.reg_dst = 1; end
      BRANCH: begin o.alu_src_a = 1; o.alu_op = 2'd1; o.pc_src = 2'd1; o.pc_en = z; end
      ADDIEX: begin o.alu_src_a = 1; o.alu_src_b = 2'd2; end
      ADDIWB: begin o.reg_write = 1; end
      JUMP:   begin o.pc_src = 2'd2; o.pc_en = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Model: after DECODE an instruction is a queue of remaining steps;
  // FETCH/MEMRD/MEMWR linger while memory is not ready.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_state = IDLE;
      m_q.delete();
    end else if (m_state == IDLE) begin
      m_state = FETCH;
    end else if ((m_state == FETCH || m_state == MEMRD || m_state == MEMWR) && !bus.mem_ready) begin
      m_state = m_state;
    end else if (m_state == FETCH) begin
      m_state = DECODE;
    end else begin
      if (m_state == DECODE) begin
        case (bus.opcode)
          6'b100011: m_q = '{MEMADR, MEMRD, MEMWB};
          6'b101011: m_q = '{MEMADR, MEMWR};
          6'b000000: m_q = '{EXEC, ALUWB};
          6'b000100: m_q = '{BRANCH};
          6'b001000: m_q = '{ADDIEX, ADDIWB};
          6'b000010: m_q = '{JUMP};
          default:   m_q.delete();
        endcase
      end
      m_state = (m_q.size() == 0) ? FETCH : m_q.pop_front();
    end
  end

  always @(negedge clk) begin
    outs_t exp_o, act_o;
    exp_o = model_outs(m_state, bus.opcode, bus.zero, bus.mem_ready);
    act_o = {bus.pc_en, bus.pc_src, bus.iord, bus.mem_rd, bus.mem_wr,
             bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
             bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.illegal};
    checks++;
    if (bus.state !== 4'(m_state)) begin
      errors++;
      $display("FAIL state t=%0t actual=%0d expected=%0d", $time, bus.state, m_state);
    end
    checks++;
    if (act_o !== exp_o) begin
      errors++;
      $display("FAIL outputs t=%0t state=%0d actual=%h expected=%h", $time, m_state, act_o, exp_o);
    end
    if (bus.mem_wr) cnt_memwr++;
    if (bus.reg_write) cnt_regwr++;
    if (bus.illegal) cnt_ill++;
    if (bus.ir_write) cnt_irw++;
    if (bus.state == 4'(BRANCH) && bus.pc_en) cnt_br++;
  end

  task automatic drive_ready();
    if (m_state == FETCH && fetch_stall > 0) begin
      bus.mem_ready = 1'b0;
      fetch_stall--;
    end else if ((m_state == MEMRD || m_state == MEMWR) && mem_stall > 0) begin
      bus.mem_ready = 1'b0;
      mem_stall--;
    end else begin
      bus.mem_ready = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_ready();
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input logic z,
                           input int fs, input int ms, input int exp_cyc,
                           input int exp_memwr, input int exp_regwr,
                           input int exp_ill, input int exp_br);
    int  n;
    bit  left;
    bus.opcode  = op;
    bus.zero    = z;
    fetch_stall = fs;
    mem_stall   = ms;
    drive_ready();
    cnt_memwr = 0; cnt_regwr = 0; cnt_ill = 0; cnt_br = 0; cnt_irw = 0;
    n = 0;
    left = 0;
    while (!(left && m_state == FETCH) && n < 60) begin
      step();
      n++;
      if (m_state != FETCH) left = 1;
    end
    check_int({name, "_cycles"}, n, exp_cyc);
    check_int({name, "_mem_wr_cycles"}, cnt_memwr, exp_memwr);
    check_int({name, "_reg_write_cycles"}, cnt_regwr, exp_regwr);
    check_int({name, "_illegal_pulses"}, cnt_ill, exp_ill);
    check_int({name, "_branch_pc_en"}, cnt_br, exp_br);
    check_int({name, "_ir_write_cycles"}, cnt_irw, 1);
  endtask

  task automatic check_idle(input string name);
    check_int({name, "_state"}, int'(bus.state), 0);
    check_int({name, "_outs"},
              int'({bus.pc_en, bus.pc_src, bus.iord, bus.mem_rd, bus.mem_wr,
                    bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                    bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.illegal}), 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.opcode    = 6'b000000;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (3) step();
    check_idle("por");
    rst_n = 1'b1;
    step();
    check_int("por_release_state", int'(bus.state), 1);
    check_int("por_release_mem_rd", int'(bus.mem_rd), 1);

    //        name     opcode     z  fs ms cyc wr rw il br
    run_instr("lw",    6'b100011, 0, 0, 0, 5,  0, 1, 0, 0);
    run_instr("sw",    6'b101011, 0, 0, 3, 7,  4, 0, 0, 0);
    run_instr("rtype", 6'b000000, 0, 0, 0, 4,  0, 1, 0, 0);
    run_instr("addi",  6'b001000, 1, 0, 0, 4,  0, 1, 0, 0);
    run_instr("beq_t", 6'b000100, 1, 0, 0, 3,  0, 0, 0, 1);
    run_instr("beq_n", 6'b000100, 0, 0, 0, 3,  0, 0, 0, 0);
    run_instr("j",     6'b000010, 0, 0, 0, 3,  0, 0, 0, 0);
    run_instr("ill",   6'b111111, 0, 0, 0, 2,  0, 0, 1, 0);
    run_instr("fstall",6'b000000, 0, 2, 0, 6,  0, 1, 0, 0);
    run_instr("lw_st", 6'b100011, 0, 1, 2, 8,  0, 1, 0, 0);

    // Reset in the middle of a long MEMRD wait
    bus.opcode = 6'b100011;
    mem_stall  = 100;
    for (int i = 0; i < 40 && m_state != MEMRD; i++) step();
    check_int("pre_reset_in_memrd", int'(bus.state), 4);
    step();
    rst_n = 1'b0;
    repeat (3) step();
    check_idle("mid_reset");
    mem_stall = 0;
    rst_n = 1'b1;
    step();
    check_int("mid_release_state", int'(bus.state), 1);
    check_int("mid_release_mem_rd", int'(bus.mem_rd), 1);
    run_instr("lw_post", 6'b100011, 0, 0, 0, 5, 0, 1, 0, 0);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
